// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline.
// Two memory-port latency FSMs, a RUN/HALT mode FSM, a DMA bus-grant flop
// and a saturating stall counter feed a fixed-priority stall/flush decoder.
module pipeline_stall_ctrl #(
   parameter int IMEM_LATENCY = 2,
   parameter int DMEM_LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        imem_req,
   input  logic        dmem_req,
   input  logic        load_use,
   input  logic        mispredict,
   input  logic        halted,
   input  logic        BR,
   output logic        BG,
   output logic        imem_ready,
   output logic        dmem_ready,
   output logic        pc_stall,
   output logic        ifid_stall,
   output logic        idex_stall,
   output logic        exmem_stall,
   output logic        memwb_stall,
   output logic        ifid_flush,
   output logic        idex_flush,
   output logic        exmem_flush,
   output logic        memwb_flush,
   output logic [15:0] stall_count
);

   typedef enum logic {MODE_RUN, MODE_HALT} mode_t;
   typedef enum logic {PORT_IDLE, PORT_WAIT} port_t;

   localparam int IW = $clog2(IMEM_LATENCY + 1);
   localparam int DW = $clog2(DMEM_LATENCY + 1);
   // WAIT entry value: WAIT lasts LAT-1 cycles, the last one (cnt==0) completing the access.
   localparam logic [IW-1:0] IMEM_RELOAD = IW'((IMEM_LATENCY > 1) ? IMEM_LATENCY - 2 : 0);
   localparam logic [DW-1:0] DMEM_RELOAD = DW'((DMEM_LATENCY > 1) ? DMEM_LATENCY - 2 : 0);

   mode_t         r_mode, w_mode_nxt;
   port_t         r_imem_state, w_imem_state_nxt;
   port_t         r_dmem_state, w_dmem_state_nxt;
   logic [IW-1:0] r_imem_cnt, w_imem_cnt_nxt;
   logic [DW-1:0] r_dmem_cnt, w_dmem_cnt_nxt;
   logic          r_bg, w_bg_nxt;
   logic [15:0]   r_stall_count;
   logic          w_run, w_imem_rdy, w_dmem_rdy, w_imem_stall, w_dmem_stall, w_dma_free;

   // Port FSMs only advance in RUN and out of reset; in HALT they are frozen.
   assign w_run = reset_n && (r_mode == MODE_RUN);

   // dmem port FSM: an access may start only while the DMA master does not own the bus.
   always_comb begin
      // NOTE: every signal assigned here gets a default first so no latch can be inferred.
      w_dmem_state_nxt = r_dmem_state;
      w_dmem_cnt_nxt   = r_dmem_cnt;
      w_dmem_rdy       = 1'b0;
      if (w_run) begin
         case (r_dmem_state)
            PORT_IDLE: begin
               if (dmem_req && !r_bg) begin
                  if (DMEM_LATENCY == 1) begin
                     w_dmem_rdy = 1'b1;
                  end else begin
                     w_dmem_state_nxt = PORT_WAIT;
                     w_dmem_cnt_nxt   = DMEM_RELOAD;
                  end
               end
            end
            PORT_WAIT: begin
               if (r_dmem_cnt != '0) begin
                  w_dmem_cnt_nxt = r_dmem_cnt - DW'(1);
               end else begin
                  w_dmem_rdy       = 1'b1;
                  w_dmem_state_nxt = PORT_IDLE;
               end
            end
         endcase
      end
   end

   assign w_dmem_stall = dmem_req && !w_dmem_rdy;

   // imem port FSM: a mispredict aborts the fetch unless EX is being held by a dmem stall.
   always_comb begin
      w_imem_state_nxt = r_imem_state;
      w_imem_cnt_nxt   = r_imem_cnt;
      w_imem_rdy       = 1'b0;
      if (w_run) begin
         case (r_imem_state)
            PORT_IDLE: begin
               if (imem_req) begin
                  if (IMEM_LATENCY == 1) begin
                     w_imem_rdy = 1'b1;
                  end else begin
                     w_imem_state_nxt = PORT_WAIT;
                     w_imem_cnt_nxt   = IMEM_RELOAD;
                  end
               end
            end
            PORT_WAIT: begin
               if (r_imem_cnt != '0) begin
                  w_imem_cnt_nxt = r_imem_cnt - IW'(1);
               end else begin
                  w_imem_rdy       = 1'b1;
                  w_imem_state_nxt = PORT_IDLE;
               end
            end
         endcase
         if (mispredict && !w_dmem_stall) begin
            w_imem_state_nxt = PORT_IDLE;
         end
      end
   end

   assign w_imem_stall = imem_req && !w_imem_rdy;
   assign imem_ready   = w_imem_rdy;
   assign dmem_ready   = w_dmem_rdy;

   // Mode next state: HALT is sticky until reset.
   always_comb begin
      w_mode_nxt = r_mode;
      if (r_mode == MODE_RUN && halted) begin
         w_mode_nxt = MODE_HALT;
      end
   end

   // Bus grant: the data port is free when idle and unrequested, or when its access completes now.
   assign w_dma_free = ((r_dmem_state == PORT_IDLE) && !dmem_req) || w_dmem_rdy;
   assign w_bg_nxt   = BR && (r_bg || w_dma_free);

   // Stall/flush decode: reset, HALT, then the RUN priority chain.
   always_comb begin
      pc_stall    = 1'b0;
      ifid_stall  = 1'b0;
      idex_stall  = 1'b0;
      exmem_stall = 1'b0;
      memwb_stall = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      memwb_flush = 1'b0;
      if (!reset_n) begin
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         exmem_flush = 1'b1;
         memwb_flush = 1'b1;
      end else if (r_mode == MODE_HALT) begin
         pc_stall    = 1'b1;
         ifid_stall  = 1'b1;
         idex_stall  = 1'b1;
         exmem_stall = 1'b1;
         memwb_stall = 1'b1;
      end else if (w_dmem_stall) begin
         pc_stall    = 1'b1;
         ifid_stall  = 1'b1;
         idex_stall  = 1'b1;
         exmem_stall = 1'b1;
         memwb_flush = 1'b1;
      end else if (mispredict) begin
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
      end else if (load_use) begin
         pc_stall    = 1'b1;
         ifid_stall  = 1'b1;
         idex_flush  = 1'b1;
      end else if (w_imem_stall) begin
         pc_stall    = 1'b1;
         ifid_flush  = 1'b1;
      end
   end

   // State registers, bus grant and saturating stall counter.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_mode        <= MODE_RUN;
         r_imem_state  <= PORT_IDLE;
         r_dmem_state  <= PORT_IDLE;
         r_imem_cnt    <= '0;
         r_dmem_cnt    <= '0;
         r_bg          <= 1'b0;
         r_stall_count <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         r_mode       <= w_mode_nxt;
         r_imem_state <= w_imem_state_nxt;
         r_dmem_state <= w_dmem_state_nxt;
         r_imem_cnt   <= w_imem_cnt_nxt;
         r_dmem_cnt   <= w_dmem_cnt_nxt;
         r_bg         <= w_bg_nxt;
         if (pc_stall && r_stall_count != 16'hFFFF) begin
            r_stall_count <= r_stall_count + 16'd1;
         end
      end
   end

   assign BG          = r_bg;
   assign stall_count = r_stall_count;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed self-checking bench for pipeline_stall_ctrl (IMEM_LATENCY=3,
// DMEM_LATENCY=3) plus a zero-wait instance for the LAT==1 paths.
module tb_pipeline_stall_ctrl;

   logic clk = 1'b0;
   logic reset_n;
   logic imem_req, dmem_req, load_use, mispredict, halted, BR;

   logic        bg, imem_ready, dmem_ready;
   logic        pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_stall;
   logic        ifid_flush, idex_flush, exmem_flush, memwb_flush;
   logic [15:0] stall_count;

   logic        z_bg, z_imem_ready, z_dmem_ready;
   logic        z_pc_stall, z_ifid_stall, z_idex_stall, z_exmem_stall, z_memwb_stall;
   logic        z_ifid_flush, z_idex_flush, z_exmem_flush, z_memwb_flush;
   logic [15:0] z_stall_count;

   logic [8:0]  ctl, z_ctl;

   int          n_assert = 0;
   int          n_fail   = 0;
   logic [15:0] exp_cnt;

   // Control vector order: pc, ifid, idex, exmem, memwb stalls | ifid, idex, exmem, memwb flushes
   localparam logic [8:0] P_ALL0   = 9'b0_0000_0000;
   localparam logic [8:0] P_RST    = 9'b0_0000_1111;
   localparam logic [8:0] P_DSTALL = 9'b1_1110_0001;
   localparam logic [8:0] P_MISP   = 9'b0_0000_1100;
   localparam logic [8:0] P_LU     = 9'b1_1000_0100;
   localparam logic [8:0] P_ISTALL = 9'b1_0000_1000;
   localparam logic [8:0] P_HALT   = 9'b1_1111_0000;

   always #5 clk = ~clk;

   pipeline_stall_ctrl #(.IMEM_LATENCY(3), .DMEM_LATENCY(3)) u_dut (
      .clk(clk), .reset_n(reset_n), .imem_req(imem_req), .dmem_req(dmem_req),
      .load_use(load_use), .mispredict(mispredict), .halted(halted), .BR(BR),
      .BG(bg), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
      .pc_stall(pc_stall), .ifid_stall(ifid_stall), .idex_stall(idex_stall),
      .exmem_stall(exmem_stall), .memwb_stall(memwb_stall),
      .ifid_flush(ifid_flush), .idex_flush(idex_flush),
      .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
      .stall_count(stall_count)
   );

   pipeline_stall_ctrl #(.IMEM_LATENCY(1), .DMEM_LATENCY(1)) u_zw (
      .clk(clk), .reset_n(reset_n), .imem_req(imem_req), .dmem_req(dmem_req),
      .load_use(load_use), .mispredict(mispredict), .halted(halted), .BR(BR),
      .BG(z_bg), .imem_ready(z_imem_ready), .dmem_ready(z_dmem_ready),
      .pc_stall(z_pc_stall), .ifid_stall(z_ifid_stall), .idex_stall(z_idex_stall),
      .exmem_stall(z_exmem_stall), .memwb_stall(z_memwb_stall),
      .ifid_flush(z_ifid_flush), .idex_flush(z_idex_flush),
      .exmem_flush(z_exmem_flush), .memwb_flush(z_memwb_flush),
      .stall_count(z_stall_count)
   );

   assign ctl   = {pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_stall,
                   ifid_flush, idex_flush, exmem_flush, memwb_flush};
   assign z_ctl = {z_pc_stall, z_ifid_stall, z_idex_stall, z_exmem_stall, z_memwb_stall,
                   z_ifid_flush, z_idex_flush, z_exmem_flush, z_memwb_flush};

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_in(input logic im, input logic dm, input logic lu,
                         input logic mp, input logic h, input logic br);
      imem_req   = im;
      dmem_req   = dm;
      load_use   = lu;
      mispredict = mp;
      halted     = h;
      BR         = br;
   endtask

   // Check this cycle's stall/flush vector, then step one clock and update the counter model.
   task automatic cyc(input string tag, input logic [8:0] exp_ctl);
      check(tag, {7'd0, ctl}, {7'd0, exp_ctl});
      @(posedge clk);
      #1;
      if (exp_ctl[8] && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
   endtask

   initial begin
      reset_n = 1'b0;
      set_in(0, 0, 0, 0, 0, 0);
      exp_cnt = 16'd0;

      // Reset state
      #1;
      check("rst_ctl", {7'd0, ctl}, {7'd0, P_RST});
      check("rst_bg", {15'd0, bg}, 16'd0);
      check("rst_count", stall_count, 16'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      #1;
      cyc("post_rst", P_ALL0);
      check("post_rst_count", stall_count, 16'd0);

      // A: dmem latency 3 with imem fetch in flight; mispredict/load_use ignored while EX held
      set_in(1, 1, 0, 0, 0, 0);
      #1;
      check("A1_dmem_ready", {15'd0, dmem_ready}, 16'd0);
      check("zw_imem_ready", {15'd0, z_imem_ready}, 16'd1);
      check("zw_dmem_ready", {15'd0, z_dmem_ready}, 16'd1);
      check("zw_ctl", {7'd0, z_ctl}, {7'd0, P_ALL0});
      cyc("A1", P_DSTALL);
      set_in(1, 1, 1, 1, 0, 0);
      #1;
      check("A2_dmem_ready", {15'd0, dmem_ready}, 16'd0);
      cyc("A2", P_DSTALL);
      set_in(1, 1, 0, 0, 0, 0);
      #1;
      check("A3_dmem_ready", {15'd0, dmem_ready}, 16'd1);
      check("A3_imem_ready", {15'd0, imem_ready}, 16'd1);
      cyc("A3", P_ALL0);
      set_in(0, 0, 0, 0, 0, 0);
      #1;
      check("A_count", stall_count, exp_cnt);
      cyc("A4", P_ALL0);

      // B: load_use together with an imem stall
      set_in(1, 0, 1, 0, 0, 0);
      #1;
      cyc("B1_lu_imem", P_LU);
      set_in(1, 0, 0, 0, 0, 0);
      #1;
      cyc("B2", P_ISTALL);
      #1;
      check("B3_imem_ready", {15'd0, imem_ready}, 16'd1);
      cyc("B3", P_ALL0);

      // C: mispredict while imem in WAIT aborts the fetch
      cyc("C1", P_ISTALL);
      set_in(1, 0, 0, 1, 0, 0);
      #1;
      cyc("C2_misp", P_MISP);
      set_in(1, 0, 0, 0, 0, 0);
      #1;
      check("C3_imem_ready", {15'd0, imem_ready}, 16'd0);
      cyc("C3_refetch", P_ISTALL);
      cyc("C4", P_ISTALL);
      #1;
      check("C5_imem_ready", {15'd0, imem_ready}, 16'd1);
      cyc("C5", P_ALL0);
      set_in(0, 0, 0, 0, 0, 0);
      #1;
      check("C_count", stall_count, exp_cnt);

      // D: bus request during a dmem access, then grant, stall under grant, release
      set_in(0, 1, 0, 0, 0, 1);
      #1;
      check("D1_bg", {15'd0, bg}, 16'd0);
      cyc("D1", P_DSTALL);
      check("D2_bg", {15'd0, bg}, 16'd0);
      cyc("D2", P_DSTALL);
      check("D3_dmem_ready", {15'd0, dmem_ready}, 16'd1);
      check("D3_bg", {15'd0, bg}, 16'd0);
      cyc("D3", P_ALL0);
      set_in(0, 0, 0, 0, 0, 1);
      #1;
      check("D4_bg", {15'd0, bg}, 16'd1);
      cyc("D4", P_ALL0);
      set_in(0, 1, 0, 0, 0, 1);
      #1;
      check("D5_dmem_ready", {15'd0, dmem_ready}, 16'd0);
      cyc("D5_req_under_bg", P_DSTALL);
      set_in(0, 0, 0, 0, 0, 0);
      #1;
      check("D6_bg_held", {15'd0, bg}, 16'd1);
      cyc("D6", P_ALL0);
      set_in(0, 1, 0, 0, 0, 0);
      #1;
      check("D7_bg_drop", {15'd0, bg}, 16'd0);
      cyc("D7", P_DSTALL);
      cyc("D8", P_DSTALL);
      check("D9_dmem_ready", {15'd0, dmem_ready}, 16'd1);
      cyc("D9", P_ALL0);

      // F: halt, DMA still served, counter saturation
      set_in(0, 0, 0, 0, 1, 0);
      #1;
      cyc("F0_halt_req", P_ALL0);
      set_in(0, 0, 0, 0, 0, 1);
      #1;
      check("F1_bg", {15'd0, bg}, 16'd0);
      cyc("F1_halt", P_HALT);
      check("F2_bg", {15'd0, bg}, 16'd1);
      cyc("F2_halt", P_HALT);
      for (int i = 0; i < 65600; i++) begin
         @(posedge clk);
         if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      end
      #1;
      check("F_count_model", stall_count, exp_cnt);
      check("F_count_sat", stall_count, 16'hFFFF);
      cyc("F3_halt", P_HALT);
      check("F3_count_hold", stall_count, 16'hFFFF);

      // Reset from HALT with BG=1: grant and counter drop at once
      #2;
      reset_n = 1'b0;
      BR      = 1'b0;
      exp_cnt = 16'd0;
      #1;
      check("rst2_ctl", {7'd0, ctl}, {7'd0, P_RST});
      check("rst2_bg", {15'd0, bg}, 16'd0);
      check("rst2_count", stall_count, 16'd0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      #1;
      cyc("rst2_post", P_ALL0);

      // G: reset in the middle of a dmem WAIT
      set_in(0, 1, 0, 0, 0, 0);
      #1;
      cyc("G1", P_DSTALL);
      #2;
      reset_n = 1'b0;
      #1;
      exp_cnt = 16'd0;
      check("G_rst_ctl", {7'd0, ctl}, {7'd0, P_RST});
      check("G_rst_dmem_ready", {15'd0, dmem_ready}, 16'd0);
      check("G_rst_bg", {15'd0, bg}, 16'd0);
      check("G_rst_count", stall_count, 16'd0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      set_in(0, 0, 0, 0, 0, 0);
      #1;
      cyc("G2", P_ALL0);
      set_in(0, 1, 0, 0, 0, 0);
      #1;
      cyc("G3_idle_restart", P_DSTALL);
      cyc("G4", P_DSTALL);
      check("G5_dmem_ready", {15'd0, dmem_ready}, 16'd1);
      cyc("G5", P_ALL0);
      set_in(0, 0, 0, 0, 0, 0);
      #1;
      check("G_count", stall_count, exp_cnt);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
